// File: rtl/dpram_adapter_pkg.sv
// Shared types and helpers for the single-port RAM request adapter.
package dpram_adapter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StMerge
  } adapter_state_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Lane-wise select: enabled lanes come from new_word, the rest from old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dpram_port_adapter.sv
// Adapts a req/gnt/rvalid core port to a registered-read RAM port, turning partial writes
// into read-modify-write. Define DPRAM_ADAPTER_RDATA_REG_EN to register the response once more.
module dpram_port_adapter
  import dpram_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ram_en_o,
  output logic                  ram_wr_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  adapter_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_hold_q;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_hold_q;
  logic [3:0]            be_q;
  logic                  latch;
  logic                  rvalid_d, rvalid_q;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign word_addr = addr_i[ADDR_WIDTH+1:2];

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    gnt_o       = 1'b0;
    ram_en_o    = 1'b0;
    ram_wr_o    = 1'b0;
    ram_addr_o  = addr_hold_q;
    ram_wdata_o = wdata_hold_q;
    rvalid_d    = 1'b0;
    latch       = 1'b0;
    // Reset masks everything, which also abandons a write caught in the merge cycle.
    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          gnt_o = req_i;
          if (req_i) begin
            if (!we_i) begin
              ram_en_o   = 1'b1;
              ram_addr_o = word_addr;
              rvalid_d   = 1'b1;
            end else if (be_i == BE_FULL) begin
              ram_en_o    = 1'b1;
              ram_wr_o    = 1'b1;
              ram_addr_o  = word_addr;
              ram_wdata_o = wdata_i;
              rvalid_d    = 1'b1;
            end else if (be_i == BE_NONE) begin
              rvalid_d = 1'b1;
            end else begin
              ram_en_o   = 1'b1;
              ram_addr_o = word_addr;
              latch      = 1'b1;
              state_d    = StMerge;
            end
          end
        end
        StMerge: begin
          ram_en_o    = 1'b1;
          ram_wr_o    = 1'b1;
          ram_addr_o  = addr_q;
          ram_wdata_o = be_merge(ram_rdata_i, wdata_q, be_q);
          rvalid_d    = 1'b1;
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      if (latch) begin
        addr_q  <= word_addr;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      // RAM address/data hold their last issued values while the port is idle.
      if (ram_en_o) begin
        addr_hold_q  <= ram_addr_o;
        wdata_hold_q <= ram_wdata_o;
      end
    end
  end

`ifdef DPRAM_ADAPTER_RDATA_REG_EN
  logic                  rvalid_r_q;
  logic [DATA_WIDTH-1:0] rdata_r_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r_q <= 1'b0;
    end else begin
      rvalid_r_q <= rvalid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_r_q <= ram_rdata_i;
  end

  assign rvalid_o = rvalid_r_q & ~rst_i;
  assign rdata_o  = rdata_r_q;
`else
  assign rvalid_o = rvalid_q & ~rst_i;
  assign rdata_o  = ram_rdata_i;
`endif

endmodule

// File: tb/tb_dpram_port_adapter.sv
// Directed self-checking bench for dpram_port_adapter with a registered-read RAM model.
module tb_dpram_port_adapter;

`ifdef DPRAM_ADAPTER_RDATA_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ram_en, ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [256];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dpram_port_adapter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .gnt_o      (gnt),
    .we_i       (we),
    .be_i       (be),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .ram_en_o   (ram_en),
    .ram_wr_o   (ram_wr),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  // Read-first registered RAM.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_wr) mem[ram_addr] = ram_wdata;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", tag, act, exp);
    else passes++;
  endtask

  // Caller aligns to the negedge first.
  task automatic drive(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  task automatic expect_resp(input string tag, input logic chk_data, input logic [31:0] exp);
    repeat (Lat - 1) begin
      idle_cycle();
      check_val({tag, "_early"}, {31'b0, rvalid}, 32'd0);
    end
    idle_cycle();
    check_val({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    if (chk_data) check_val({tag, "_rdata"}, rdata, exp);
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b0, 4'hF, a, 32'h0);
    check_val({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
    expect_resp(tag, 1'b1, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[12] = 32'hAABBCCDD;
    mem[16] = 32'h12345678;
    mem[20] = 32'h55667788;

    // Reset with a pending request: nothing may leak out.
    @(negedge clk);
    drive(1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);
    #1;
    check_val("rst_gnt", {31'b0, gnt}, 32'd0);
    check_val("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check_val("rst_en", {31'b0, ram_en}, 32'd0);
    check_val("rst_wr", {31'b0, ram_wr}, 32'd0);

    // First grant in the first cycle after reset release.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'hF, 32'h10, 32'h0);
    check_val("rd_gnt", {31'b0, gnt}, 32'd1);
    check_val("rd_en", {31'b0, ram_en}, 32'd1);
    check_val("rd_wr", {31'b0, ram_wr}, 32'd0);
    check_val("rd_addr", {24'b0, ram_addr}, 32'd4);
    expect_resp("rd", 1'b1, 32'hDEADBEEF);

    // Full write then read back.
    @(negedge clk);
    drive(1'b1, 4'hF, 32'h20, 32'h11223344);
    check_val("wf_gnt", {31'b0, gnt}, 32'd1);
    check_val("wf_en", {31'b0, ram_en}, 32'd1);
    check_val("wf_wr", {31'b0, ram_wr}, 32'd1);
    check_val("wf_addr", {24'b0, ram_addr}, 32'd8);
    check_val("wf_wdata", ram_wdata, 32'h11223344);
    expect_resp("wf", 1'b0, 32'h0);
    read_word("wf_rb", 32'h20, 32'h11223344);

    // Partial write: read in grant cycle, merged write one cycle later.
    @(negedge clk);
    drive(1'b1, 4'b0010, 32'h30, 32'h00001100);
    check_val("pw_gnt", {31'b0, gnt}, 32'd1);
    check_val("pw_rd_en", {31'b0, ram_en}, 32'd1);
    check_val("pw_rd_wr", {31'b0, ram_wr}, 32'd0);
    @(negedge clk);
    #1;
    check_val("pw_merge_gnt", {31'b0, gnt}, 32'd0);
    check_val("pw_merge_en", {31'b0, ram_en}, 32'd1);
    check_val("pw_merge_wr", {31'b0, ram_wr}, 32'd1);
    check_val("pw_merge_addr", {24'b0, ram_addr}, 32'd12);
    check_val("pw_merge_wdata", ram_wdata, 32'hAABB11DD);
    check_val("pw_merge_rvalid", {31'b0, rvalid}, 32'd0);
    expect_resp("pw", 1'b0, 32'h0);
    read_word("pw_rb", 32'h30, 32'hAABB11DD);

    // Empty write: no RAM access, address output keeps its last value.
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h40, 32'hFFFFFFFF);
    check_val("w0_gnt", {31'b0, gnt}, 32'd1);
    check_val("w0_en", {31'b0, ram_en}, 32'd0);
    check_val("w0_addr_hold", {24'b0, ram_addr}, 32'd12);
    expect_resp("w0", 1'b0, 32'h0);
    read_word("w0_rb", 32'h40, 32'h12345678);

    // Reset during merge abandons the write and its response.
    @(negedge clk);
    drive(1'b1, 4'b0001, 32'h50, 32'h000000EE);
    check_val("ab_gnt", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    #1;
    check_val("ab_wr", {31'b0, ram_wr}, 32'd0);
    check_val("ab_en", {31'b0, ram_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("ab_rvalid0", {31'b0, rvalid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      idle_cycle();
      check_val("ab_rvalid", {31'b0, rvalid}, 32'd0);
    end
    read_word("ab_rb", 32'h50, 32'h55667788);

    // Eight back-to-back alternating full writes and reads.
    for (int c = 0; c < 8 + Lat; c++) begin
      @(negedge clk);
      if (c < 8) begin
        if (c % 2 == 0) drive(1'b1, 4'hF, 32'h60 + 32'(c / 2) * 4, 32'hC0DE0000 + 32'(c));
        else drive(1'b0, 4'hF, 32'h60 + 32'(c / 2) * 4, 32'h0);
        check_val("b2b_gnt", {31'b0, gnt}, 32'd1);
      end else begin
        req = 1'b0;
        #1;
      end
      if (c < Lat) begin
        check_val("b2b_rvalid_pre", {31'b0, rvalid}, 32'd0);
      end else begin
        check_val("b2b_rvalid", {31'b0, rvalid}, 32'd1);
        if ((c - Lat) % 2 == 1) check_val("b2b_rdata", rdata, 32'hC0DE0000 + 32'(c - Lat - 1));
      end
    end
    idle_cycle();
    check_val("b2b_rvalid_post", {31'b0, rvalid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
